// File: rtl/cla_pkg.sv
// Shared types and constants for the serial carry-lookahead add/sub controller.
package cla_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_ctrl_state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3 for overflow detection.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co,
  output logic               c3
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic               c1;
  logic               c2;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p and ci; no ripple between bits.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Sequences one shared 4-bit CLA slice over WIDTH-bit operands, one nibble per clock, LSB first.
// One operation in flight; result is held in DONE until rsp_ready.
module cla_serial_add_ctrl
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  input  logic             req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf
);

  localparam int unsigned NIB    = WIDTH / SLICE_W;
  localparam int unsigned STEP_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NIB - 1);

  cla_ctrl_state_t   state_q, state_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic              carry_q, carry_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic [SLICE_W-1:0] sl_s;
  logic               sl_co;
  logic               sl_c3;

  cla4_slice u_slice (
    .a  (op_a_q[SLICE_W-1:0]),
    .b  (op_b_q[SLICE_W-1:0]),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co),
    .c3 (sl_c3)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    step_d  = step_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = RUN;
          op_a_d  = req_a;
          op_b_d  = req_sub ? ~req_b : req_b;
          carry_d = req_sub ? 1'b1 : req_cin;
          step_d  = '0;
        end
      end
      RUN: begin
        // Slice result enters at the top so after the last step the LSB nibble sits at bit 0.
        sum_d   = (sum_q >> SLICE_W) | (WIDTH'(sl_s) << (WIDTH - SLICE_W));
        op_a_d  = op_a_q >> SLICE_W;
        op_b_d  = op_b_q >> SLICE_W;
        carry_d = sl_co;
        step_d  = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) begin
          cout_d  = sl_co;
          ovf_d   = sl_c3 ^ sl_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      carry_q     <= 1'b0;
      step_q      <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      carry_q     <= carry_d;
      step_q      <= step_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Scoreboard bench for cla_serial_add_ctrl: three instances (WIDTH 16, 4, 32) each driven
// with directed and random traffic, checked against an integer-arithmetic reference.
module tb_cla_serial_add_ctrl;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
  } vec_t;

  vec_t vecs [7] = '{
    '{16'hFFFF, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0},
    '{16'h0005, 16'h0007, 1'b0, 1'b1},
    '{16'h8000, 16'h0001, 1'b0, 1'b1},
    '{16'h0005, 16'h0007, 1'b1, 1'b1},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 1'b0}
  };

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain (w+1)-bit addition; overflow from operand/result sign bits.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] mask, aa, bb;
    logic [64:0] full;
    exp_t e;
    mask   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa     = a & mask;
    bb     = (sub ? ~b : b) & mask;
    full   = {1'b0, aa} + {1'b0, bb} + 65'(sub ? 1'b1 : cin);
    e.sum  = full[63:0] & mask;
    e.cout = full[w];
    e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
    return e;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int unsigned W   = (gi == 0) ? 16 : (gi == 1) ? 4 : 32;
    localparam int          NIB = W / 4;
    localparam int          ABORT_WAIT = (NIB > 2) ? 2 : NIB - 1;

    logic         rst_n     = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a     = '0;
    logic [W-1:0] req_b     = '0;
    logic         req_cin   = 1'b0;
    logic         req_sub   = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;

    int           rdy_mode = 0;
    exp_t         q[$];
    exp_t         e;
    logic         held = 1'b0;
    logic [W-1:0] h_sum;
    logic         h_cout;
    logic         h_ovf;

    cla_serial_add_ctrl #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_sub   (req_sub),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_ovf   (rsp_ovf)
    );

    task automatic c(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk($sformatf("w%0d_%s", W, name), act, exp);
    endtask

    // rsp_ready policy: 0 = hold low, 1 = hold high, else random stalls.
    always @(posedge clk) begin
      #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end

    // Monitor: pops on every response handshake; checks hold stability while stalled.
    always @(negedge clk) begin
      if (!rst_n) begin
        held = 1'b0;
      end else if (rsp_valid) begin
        if (held) begin
          c("hold_sum", 64'(rsp_sum), 64'(h_sum));
          c("hold_flags", 64'({rsp_cout, rsp_ovf}), 64'({h_cout, h_ovf}));
        end
        if (rsp_ready) begin
          held = 1'b0;
          if (q.size() == 0) begin
            c("unexpected_rsp", 64'(q.size()), 64'd1);
          end else begin
            e = q.pop_front();
            c("sum", 64'(rsp_sum), e.sum);
            c("cout", 64'(rsp_cout), 64'(e.cout));
            c("ovf", 64'(rsp_ovf), 64'(e.ovf));
          end
        end else begin
          held   = 1'b1;
          h_sum  = rsp_sum;
          h_cout = rsp_cout;
          h_ovf  = rsp_ovf;
        end
      end else if (held) begin
        c("valid_drop", 64'(rsp_valid), 64'd1);
        held = 1'b0;
      end
    end

    // Waits (bounded) for req_ready, offers one request, returns at the negedge after accept.
    task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input bit keep, output int waited);
      waited = 0;
      while (!req_ready && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!req_ready) c("req_ready_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_cin   = cin;
      req_sub   = sub;
      q.push_back(model(W, 64'(a), 64'(b), cin, sub));
      @(posedge clk);
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || rsp_valid) && n < 400) begin
        @(negedge clk);
        n++;
      end
      c("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
      int           w;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           sel;

      // Reset state
      rdy_mode = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      c("rst_req_ready", 64'(req_ready), 64'd1);
      c("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      c("rst_sum", 64'(rsp_sum), 64'd0);
      c("rst_flags", 64'({rsp_cout, rsp_ovf}), 64'd0);

      // Basic add, latency and hold while rsp_ready stays low
      do_req(W'(16'h1234), W'(16'h1111), 1'b0, 1'b0, 1'b0, w);
      repeat (NIB - 1) @(negedge clk);
      c("lat_early", 64'(rsp_valid), 64'd0);
      c("ready_in_run", 64'(req_ready), 64'd0);
      @(negedge clk);
      c("lat_valid", 64'(rsp_valid), 64'd1);
      repeat (4) @(negedge clk);
      c("ready_in_done", 64'(req_ready), 64'd0);
      c("valid_held", 64'(rsp_valid), 64'd1);
      rdy_mode = 1;
      wait_idle();

      // Carry/borrow boundary vectors with random response stalls
      rdy_mode = 2;
      for (int i = 0; i < 7; i++)
        do_req(W'(vecs[i].a), W'(vecs[i].b), vecs[i].cin, vecs[i].sub, 1'b0, w);
      rdy_mode = 1;
      wait_idle();

      // Back-to-back issue interval
      do_req(W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0, w);
      do_req(W'($urandom), W'($urandom), 1'b1, 1'b0, 1'b0, w);
      c("issue_interval", 64'(w + 1), 64'(NIB + 2));
      wait_idle();

      // req_valid held with changing operands through RUN and DONE
      rdy_mode = 0;
      do_req(W'(16'hA5C3), W'(16'h3C5A), 1'b1, 1'b0, 1'b1, w);
      for (int k = 0; k < NIB + 3; k++) begin
        c("hs_ready_busy", 64'(req_ready), 64'd0);
        req_a   = W'($urandom);
        req_b   = W'($urandom);
        req_sub = 1'($urandom);
        req_cin = 1'($urandom);
        @(negedge clk);
      end
      rdy_mode = 1;
      c("hs_ready_done", 64'(req_ready), 64'd0);
      @(negedge clk);
      c("hs_ready_at_hs", 64'(req_ready), 64'd0);
      @(negedge clk);
      c("hs_ready_after", 64'(req_ready), 64'd1);
      c("hs_valid_after", 64'(rsp_valid), 64'd0);
      req_valid = 1'b0;
      wait_idle();

      // Reset mid-RUN aborts the operation
      do_req(W'($urandom), W'($urandom), 1'b1, 1'b0, 1'b0, w);
      repeat (ABORT_WAIT) @(negedge clk);
      rst_n = 1'b0;
      #1;
      c("abort_valid", 64'(rsp_valid), 64'd0);
      c("abort_sum", 64'(rsp_sum), 64'd0);
      c("abort_flags", 64'({rsp_cout, rsp_ovf}), 64'd0);
      c("abort_ready", 64'(req_ready), 64'd1);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      do_req(W'(16'h1234), W'(16'h1111), 1'b0, 1'b0, 1'b0, w);
      wait_idle();

      // Random ADD/SUB with stalls and idle gaps
      rdy_mode = 2;
      for (int i = 0; i < 1000; i++) begin
        sel = $urandom_range(0, 7);
        ra  = (sel == 0) ? '1 : (sel == 1) ? '0 : W'({$urandom, $urandom});
        sel = $urandom_range(0, 7);
        rb  = (sel == 0) ? '1 : (sel == 1) ? '0 : W'({$urandom, $urandom});
        do_req(ra, rb, 1'($urandom), 1'($urandom), 1'b0, w);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      rdy_mode = 1;
      wait_idle();
      n_done++;
    end
  end

  initial begin
    fork
      begin
        wait (n_done == 3);
      end
      begin
        #800000;
        n_cmp++;
        n_bad++;
        $display("FAIL global_timeout: finished %0d of 3 instances", n_done);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
